// File: rtl/sdn_parser_pkg.sv
// Shared constants and types for the SDN parser ingress FIFO.
// Holds default AXIS widths, write-FSM encodings and the stored-entry width.
package sdn_parser_pkg;

  localparam int PRS_RX_DATA_W_DEF = 512;
  localparam int PRS_RX_KEEP_W_DEF = PRS_RX_DATA_W_DEF / 8;
  localparam int PRS_RX_ENTRY_W    = PRS_RX_DATA_W_DEF + PRS_RX_KEEP_W_DEF + 1;

  typedef enum logic {
    ST_ACCEPT = 1'b0,
    ST_DROP   = 1'b1
  } wr_state_e;

  // Stored entry is {tlast, tkeep, tdata}
  function automatic int entry_w(input int data_w, input int keep_w);
    return data_w + keep_w + 1;
  endfunction

endpackage

// File: rtl/sdn_parser_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port (1-cycle latency).
// The read register holds its value when i_rd_en is low, so it doubles as an output stage.
module sdn_parser_sdp_ram
  import sdn_parser_pkg::*;
#(
  parameter int WIDTH  = PRS_RX_ENTRY_W,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [WIDTH-1:0]  i_wr_data,
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [WIDTH-1:0]  o_rd_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rd_data;

  always_ff @(posedge i_clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)        r_rd_data <= '0;
    else if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/sdn_parser_rx_fifo.sv
// Packet-mode ingress FIFO: stores whole packets, releases only complete ones, drops whole on overflow.
//   state     | meaning
//   ST_ACCEPT | writing beats of the current packet into storage
//   ST_DROP   | discarding the rest of an overflowed packet until its tlast
module sdn_parser_rx_fifo
  import sdn_parser_pkg::*;
#(
  parameter int PRS_RX_DATA_W = PRS_RX_DATA_W_DEF,
  parameter int PRS_RX_KEEP_W = PRS_RX_DATA_W / 8,
  parameter int FIFO_DEPTH    = 64,
  parameter int ADDR_W        = $clog2(FIFO_DEPTH)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     s_axis_tvalid_i,
  input  logic [PRS_RX_DATA_W-1:0] s_axis_tdata_i,
  input  logic [PRS_RX_KEEP_W-1:0] s_axis_tkeep_i,
  input  logic                     s_axis_tlast_i,
  output logic                     s_axis_tready_o,
  output logic                     parser_axis_rx_tvalid_o,
  output logic [PRS_RX_DATA_W-1:0] parser_axis_rx_tdata_o,
  output logic [PRS_RX_KEEP_W-1:0] parser_axis_rx_tkeep_o,
  output logic                     parser_axis_rx_tlast_o,
  input  logic                     parser_axis_rx_tready_i,
  output logic                     drop_o,
  output logic [31:0]              drop_cnt_o,
  output logic [ADDR_W:0]          pkt_cnt_o
);

  localparam int PTR_W   = ADDR_W + 1;
  localparam int ENTRY_W = entry_w(PRS_RX_DATA_W, PRS_RX_KEEP_W);

  wr_state_e          r_state, w_state_nxt;
  logic [PTR_W-1:0]   r_wr_spec, r_wr_commit, r_rd_ptr;
  logic               r_tready, r_out_vld, r_drop;
  logic [31:0]        r_drop_cnt;
  logic [PTR_W-1:0]   r_pkt_cnt;

  logic               w_accept, w_full, w_wr_en, w_commit, w_drop;
  logic               w_avail, w_rd_en, w_pkt_out;
  logic [PTR_W-1:0]   w_fill;
  logic [ENTRY_W-1:0] w_rd_data;

  assign w_accept = s_axis_tvalid_i & r_tready;
  assign w_fill   = r_wr_spec - r_rd_ptr;
  assign w_full   = (w_fill == PTR_W'(FIFO_DEPTH));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_ACCEPT;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_ACCEPT: if (w_accept && w_full && !s_axis_tlast_i) w_state_nxt = ST_DROP;
      ST_DROP:   if (w_accept && s_axis_tlast_i)            w_state_nxt = ST_ACCEPT;
      default:   w_state_nxt = ST_ACCEPT;
    endcase
  end

  always_comb begin
    w_wr_en  = 1'b0;
    w_commit = 1'b0;
    w_drop   = 1'b0;
    if (r_state == ST_ACCEPT && w_accept) begin
      if (w_full) begin
        w_drop = 1'b1;
      end else begin
        w_wr_en  = 1'b1;
        w_commit = s_axis_tlast_i;
      end
    end
  end

  // The RAM read register is the parser-facing output stage; reading only when it is free or drained.
  assign w_avail   = (r_rd_ptr != r_wr_commit);
  assign w_rd_en   = w_avail & (~r_out_vld | parser_axis_rx_tready_i);
  assign w_pkt_out = r_out_vld & parser_axis_rx_tready_i & parser_axis_rx_tlast_o;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_spec   <= '0;
      r_wr_commit <= '0;
      r_rd_ptr    <= '0;
      r_tready    <= 1'b0;
      r_out_vld   <= 1'b0;
      r_drop      <= 1'b0;
      r_drop_cnt  <= '0;
      r_pkt_cnt   <= '0;
    end else begin
      r_tready <= 1'b1;
      r_drop   <= w_drop;
      if (w_drop)       r_wr_spec <= r_wr_commit;
      else if (w_wr_en) r_wr_spec <= r_wr_spec + PTR_W'(1);
      if (w_commit) r_wr_commit <= r_wr_spec + PTR_W'(1);
      if (w_rd_en)  r_rd_ptr    <= r_rd_ptr + PTR_W'(1);
      if (w_rd_en)                      r_out_vld <= 1'b1;
      else if (parser_axis_rx_tready_i) r_out_vld <= 1'b0;
      if (w_drop && r_drop_cnt != 32'hFFFF_FFFF) r_drop_cnt <= r_drop_cnt + 32'd1;
      case ({w_commit, w_pkt_out})
        2'b10:   r_pkt_cnt <= r_pkt_cnt + PTR_W'(1);
        2'b01:   r_pkt_cnt <= r_pkt_cnt - PTR_W'(1);
        default: r_pkt_cnt <= r_pkt_cnt;
      endcase
    end
  end

  sdn_parser_sdp_ram #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .i_clk    (clk),
    .i_rst    (reset),
    .i_wr_en  (w_wr_en),
    .i_wr_addr(r_wr_spec[ADDR_W-1:0]),
    .i_wr_data({s_axis_tlast_i, s_axis_tkeep_i, s_axis_tdata_i}),
    .i_rd_en  (w_rd_en),
    .i_rd_addr(r_rd_ptr[ADDR_W-1:0]),
    .o_rd_data(w_rd_data)
  );

  assign {parser_axis_rx_tlast_o, parser_axis_rx_tkeep_o, parser_axis_rx_tdata_o} = w_rd_data;
  assign parser_axis_rx_tvalid_o = r_out_vld;
  assign s_axis_tready_o         = r_tready;
  assign drop_o                  = r_drop;
  assign drop_cnt_o              = r_drop_cnt;
  assign pkt_cnt_o               = r_pkt_cnt;

endmodule

// File: tb/tb_sdn_parser_rx_fifo.sv
// Directed bench for sdn_parser_rx_fifo at FIFO_DEPTH=8, 64-bit data.
// Packet-level vector table plus hand-written sequences for latency, overflow, backpressure and reset.
module tb_sdn_parser_rx_fifo;
  localparam int DW = 64;
  localparam int KW = 8;
  localparam int DEPTH = 8;
  localparam int AW = 3;

  typedef logic [DW+KW:0] beat_t;
  typedef struct {
    int         len;
    logic [7:0] last_keep;
    bit         kept;
  } vec_t;

  logic          clk, reset;
  logic          s_tvalid, s_tlast, s_tready;
  logic [DW-1:0] s_tdata;
  logic [KW-1:0] s_tkeep;
  logic          p_tvalid, p_tlast, p_tready;
  logic [DW-1:0] p_tdata;
  logic [KW-1:0] p_tkeep;
  logic          drop;
  logic [31:0]   drop_cnt;
  logic [AW:0]   pkt_cnt;

  int    n_checks = 0;
  int    n_fail = 0;
  beat_t exp_q[$];
  beat_t act_q[$];
  int    act_idx = 0;
  int    drop_pulses = 0;
  int    stab_err = 0;
  logic  prev_stall = 1'b0;
  beat_t prev_beat = '0;
  beat_t w_out;
  vec_t  vecs[8];
  int    exp_drops;

  sdn_parser_rx_fifo #(.PRS_RX_DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk                    (clk),
    .reset                  (reset),
    .s_axis_tvalid_i        (s_tvalid),
    .s_axis_tdata_i         (s_tdata),
    .s_axis_tkeep_i         (s_tkeep),
    .s_axis_tlast_i         (s_tlast),
    .s_axis_tready_o        (s_tready),
    .parser_axis_rx_tvalid_o(p_tvalid),
    .parser_axis_rx_tdata_o (p_tdata),
    .parser_axis_rx_tkeep_o (p_tkeep),
    .parser_axis_rx_tlast_o (p_tlast),
    .parser_axis_rx_tready_i(p_tready),
    .drop_o                 (drop),
    .drop_cnt_o             (drop_cnt),
    .pkt_cnt_o              (pkt_cnt)
  );

  assign w_out = {p_tlast, p_tkeep, p_tdata};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (reset) begin
      act_q.delete();
      drop_pulses = 0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (!p_tvalid || w_out !== prev_beat)) stab_err++;
      if (p_tvalid && p_tready) act_q.push_back(w_out);
      if (drop) drop_pulses++;
      prev_stall = p_tvalid && !p_tready;
      prev_beat = w_out;
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = '0; s_tkeep = '0; p_tready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset tready_o", s_tready, 0);
    chk("reset tvalid_o", p_tvalid, 0);
    chk("reset out beat", w_out, 0);
    chk("reset drop_cnt", drop_cnt, 0);
    chk("reset pkt_cnt", pkt_cnt, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    act_idx = 0;
    exp_q.delete();
    step();
    step();
    chk("post-reset tready_o", s_tready, 1);
  endtask

  task automatic send_pkt(input logic [63:0] base, input int len, input logic [7:0] lkeep, input bit kept);
    for (int i = 0; i < len; i++) begin
      s_tvalid = 1'b1;
      s_tdata  = base + 64'(i);
      s_tkeep  = (i == len - 1) ? lkeep : 8'hFF;
      s_tlast  = (i == len - 1);
      if (kept) exp_q.push_back({s_tlast, s_tkeep, s_tdata});
      step();
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic compare_q(input string name);
    chk({name, " count"}, act_q.size() - act_idx, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (act_idx + i < act_q.size()) chk({name, " beat"}, act_q[act_idx + i], exp_q[i]);
    act_idx = act_q.size();
    exp_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    beat_t s1_exp[3];
    vecs[0] = '{3, 8'h0F, 1'b1};
    vecs[1] = '{1, 8'h01, 1'b1};
    vecs[2] = '{8, 8'hFF, 1'b1};
    vecs[3] = '{9, 8'h3C, 1'b0};
    vecs[4] = '{2, 8'h80, 1'b1};
    vecs[5] = '{10, 8'hFF, 1'b0};
    vecs[6] = '{5, 8'h7F, 1'b1};
    vecs[7] = '{4, 8'h03, 1'b1};

    // Table: one packet per vector, parser always ready, idle gap to drain.
    do_reset();
    exp_drops = 0;
    for (int v = 0; v < 8; v++) begin
      send_pkt(64'h1000 * 64'(v + 1), vecs[v].len, vecs[v].last_keep, vecs[v].kept);
      if (!vecs[v].kept) exp_drops++;
      repeat (12) step();
      chk("vec drop_cnt", drop_cnt, exp_drops);
      chk("vec drop pulses", drop_pulses, exp_drops);
      chk("vec pkt_cnt", pkt_cnt, 0);
      compare_q("vec");
    end

    // Single packet latency: tlast in T, beats valid T+2..T+4.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      s_tvalid = 1'b1;
      s_tdata  = 64'hA000 + 64'(i);
      s_tkeep  = (i == 2) ? 8'h0F : 8'hFF;
      s_tlast  = (i == 2);
      s1_exp[i] = {s_tlast, s_tkeep, s_tdata};
      if (i < 2) step();
    end
    @(negedge clk);
    chk("s1 pkt_cnt at T", pkt_cnt, 0);
    chk("s1 tvalid at T", p_tvalid, 0);
    step();
    s_tvalid = 1'b0; s_tlast = 1'b0;
    @(negedge clk);
    chk("s1 tvalid at T+1", p_tvalid, 0);
    chk("s1 pkt_cnt at T+1", pkt_cnt, 1);
    for (int k = 0; k < 3; k++) begin
      step();
      @(negedge clk);
      chk("s1 tvalid beat", p_tvalid, 1);
      chk("s1 beat", w_out, s1_exp[k]);
    end
    step();
    @(negedge clk);
    chk("s1 tvalid after", p_tvalid, 0);
    chk("s1 pkt_cnt after", pkt_cnt, 0);
    chk("s1 drop pulses", drop_pulses, 0);

    // Fill then overflow with the parser stalled.
    do_reset();
    p_tready = 1'b0;
    send_pkt(64'h200, 8, 8'hFF, 1'b1);
    send_pkt(64'h300, 3, 8'h0F, 1'b0);
    repeat (2) step();
    chk("s2 drop pulses", drop_pulses, 1);
    chk("s2 drop_cnt", drop_cnt, 1);
    chk("s2 pkt_cnt", pkt_cnt, 1);
    p_tready = 1'b1;
    repeat (12) step();
    compare_q("s2");
    chk("s2 pkt_cnt drained", pkt_cnt, 0);

    // Oversize packet, then a short one.
    do_reset();
    send_pkt(64'h400, 10, 8'hFF, 1'b0);
    repeat (3) step();
    chk("s3 drop_cnt", drop_cnt, 1);
    chk("s3 nothing out", act_q.size(), 0);
    send_pkt(64'h480, 2, 8'h1F, 1'b1);
    repeat (6) step();
    compare_q("s3");
    chk("s3 drop pulses", drop_pulses, 1);

    // Backpressure: tready toggles every other cycle.
    do_reset();
    stab_err = 0;
    fork
      send_pkt(64'h500, 5, 8'h07, 1'b1);
      for (int i = 0; i < 24; i++) begin
        p_tready = ((i / 2) % 2 == 1);
        step();
      end
    join
    p_tready = 1'b1;
    repeat (6) step();
    compare_q("s4");
    chk("s4 stability errors", stab_err, 0);

    // Wrap-around: 20 back-to-back 3-beat packets.
    do_reset();
    for (int p = 0; p < 20; p++) send_pkt(64'h5000 + 64'(16 * p), 3, 8'h3F, 1'b1);
    repeat (10) step();
    compare_q("s5");
    chk("s5 drop_cnt", drop_cnt, 0);
    chk("s5 pkt_cnt", pkt_cnt, 0);

    // Reset mid-packet with a stored packet waiting.
    do_reset();
    p_tready = 1'b0;
    send_pkt(64'h600, 2, 8'h0F, 1'b0);
    repeat (3) step();
    chk("s6 stored pkt_cnt", pkt_cnt, 1);
    chk("s6 stored tvalid", p_tvalid, 1);
    for (int i = 0; i < 2; i++) begin
      s_tvalid = 1'b1; s_tdata = 64'h680 + 64'(i); s_tkeep = 8'hFF; s_tlast = 1'b0;
      step();
    end
    reset = 1'b1;
    s_tvalid = 1'b0;
    #2;
    chk("s6 rst tready_o", s_tready, 0);
    chk("s6 rst tvalid", p_tvalid, 0);
    chk("s6 rst out beat", w_out, 0);
    chk("s6 rst drop", drop, 0);
    chk("s6 rst pkt_cnt", pkt_cnt, 0);
    chk("s6 rst drop_cnt", drop_cnt, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    p_tready = 1'b1;
    act_idx = 0;
    exp_q.delete();
    repeat (2) step();
    send_pkt(64'h700, 2, 8'h33, 1'b1);
    repeat (6) step();
    compare_q("s6");
    chk("s6 drop_cnt", drop_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sdn_parser_rx_fifo.md
# sdn_parser_rx_fifo

Packet-mode ingress FIFO directly upstream of the SDN parser fetch stage. It accepts the raw AXI-Stream packet feed, stores each packet in full, and releases only complete packets to the parser. Packets that do not fit are dropped whole, so the parser never sees a truncated frame. The block also reports drops through a pulse and a counter.

## Interface
- `PRS_RX_DATA_W`, 512, data bus width in bits.
- `PRS_RX_KEEP_W`, `PRS_RX_DATA_W/8`, byte-enable width.
- `FIFO_DEPTH`, 64, storage depth in beats; must be a power of 2 and at least 4.
- `ADDR_W`, `$clog2(FIFO_DEPTH)`, address width. Pointers are `ADDR_W+1` bits.
- `clk`  in  1  single clock; all logic is on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `s_axis_tvalid_i`  in  1  upstream beat valid.
- `s_axis_tdata_i`  in  PRS_RX_DATA_W  upstream data.
- `s_axis_tkeep_i`  in  PRS_RX_KEEP_W  upstream byte enables.
- `s_axis_tlast_i`  in  1  last beat of packet.
- `s_axis_tready_o`  out  1  0 in reset, 1 otherwise. Overflow is handled by dropping, never by backpressure.
- `parser_axis_rx_tvalid_o`  out  1  beat valid toward the parser.
- `parser_axis_rx_tdata_o`  out  PRS_RX_DATA_W  data toward the parser.
- `parser_axis_rx_tkeep_o`  out  PRS_RX_KEEP_W  byte enables toward the parser.
- `parser_axis_rx_tlast_o`  out  1  last beat toward the parser.
- `parser_axis_rx_tready_i`  in  1  parser accepts the beat.
- `drop_o`  out  1  one-cycle pulse per dropped packet.
- `drop_cnt_o`  out  32  dropped-packet count; saturates at 0xFFFFFFFF.
- `pkt_cnt_o`  out  ADDR_W+1  number of complete packets currently stored.

All outputs reset to 0.

## Operation
- **Pointers.**
  - `wr_spec` is the speculative write pointer.
  - `wr_commit` is the committed write pointer.
  - `rd_ptr` is the read pointer.
  - All three are `ADDR_W+1` bits and wrap naturally.
  - Full when `wr_spec - rd_ptr == FIFO_DEPTH`.
- **Write FSM.** States are ST_ACCEPT (reset state) and ST_DROP.
  - **ST_ACCEPT, beat accepted, not full:** write {tlast, tkeep, tdata} at `wr_spec`; `wr_spec++`.
    - If tlast: `wr_commit <= wr_spec+1` and `pkt_cnt++`.
  - **ST_ACCEPT, beat accepted, full:** `wr_spec <= wr_commit` (rewind), `drop_o` pulses next cycle, `drop_cnt++`.
    - If this beat is tlast, stay in ST_ACCEPT.
    - Otherwise go to ST_DROP.
  - **ST_DROP:** discard beats. On a tlast beat, return to ST_ACCEPT. No further drop pulse for the same packet.
- **Oversize packets.** A packet longer than `FIFO_DEPTH` beats is always dropped.
- **Read side.**
  - Data is available when `rd_ptr != wr_commit`.
  - A one-entry output register feeds the parser; it is refilled on the same cycle it is consumed, giving one beat per cycle when data is back-to-back.
  - A beat leaving with tlast=1 decrements `pkt_cnt`.
- **Simultaneous tlast write and tlast read.** `pkt_cnt` is unchanged.
- **Output stability.** tdata, tkeep and tlast hold stable while tvalid=1 and tready=0.
- **Reset mid-operation.** All pointers, FSM state, counters and the output register clear. Partial or stored packets are lost, and no drop is counted for them.

## Timing
- **Packet latency:** if the tlast beat is accepted in cycle T, the first beat of that packet is valid on `parser_axis_rx_*` in cycle T+2. The commit registers at end of T, RAM read is in T+1, and the output register is valid in T+2.
- **Throughput:** one beat per cycle on each side, sustained.
- **Drop pulse:** `drop_o` is asserted in the cycle after the overflowing beat.
- **Space freed by reads:** freed in cycle T is visible to the full check in T+1.

## Structure
- **Package `sdn_parser_pkg`:**
  - AXIS width constants.
  - FSM state encodings ST_ACCEPT/ST_DROP.
  - Stored-entry width constant `PRS_RX_DATA_W+PRS_RX_KEEP_W+1`.
- **Sub-module `sdn_parser_sdp_ram`:**
  - Simple dual-port RAM with one write port and one read port.
  - Registered read, one-cycle latency.
  - Parameters: width, depth.

## Test plan
All scenarios use `FIFO_DEPTH=8`.
1. **Single packet, parser ready:** 3-beat packet with tlast in cycle 10 and tkeep of last beat = 0x0F → beats on the parser side in cycles 12–14, last tkeep=0x0F, `pkt_cnt_o` 1→0, `drop_o` never asserted.
2. **Fill then overflow:** parser tready=0; send an 8-beat packet, then a 3-beat packet → first packet kept (`pkt_cnt_o`=1), second dropped, `drop_o` is a single pulse, `drop_cnt_o`=1. After tready=1, exactly 8 beats emerge.
3. **Oversize packet:** 10-beat packet into an empty FIFO → dropped at beat 9, `drop_cnt_o`=1, nothing output. A following 2-beat packet passes intact.
4. **Backpressure stability:** toggle tready every other cycle on a 5-beat packet → each beat is presented until accepted, data matches input order, no duplicates.
5. **Wrap-around:** 20 back-to-back 3-beat packets with tready=1 → all 60 beats output in order, `drop_cnt_o`=0, pointers wrap without error.
6. **Reset mid-packet:** assert `reset` after beat 2 of 4 → all outputs 0 and `s_axis_tready_o`=0 during reset. Afterwards a new 2-beat packet passes, `drop_cnt_o`=0.
